mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Initiator-side block mastering the single-port data memory: copies a byte range from one address to another or fills a range with a constant, with no CPU involvement. Sits between the control path (start/parameter registers) and the data memory's write-enable, read-enable, address, write-data and read-data ports. It drives exactly one memory operation per cycle and never asserts read and write enables together.

## Interface
- ADDR_WIDTH, 8, memory address width; pointers wrap modulo 2^ADDR_WIDTH
- DATA_WIDTH, 8, memory data width
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill
- src_addr  input  ADDR_WIDTH  first source address (copy only)
- dst_addr  input  ADDR_WIDTH  first destination address
- length  input  ADDR_WIDTH+1  byte count, 0..511
- fill_value  input  DATA_WIDTH  constant written in fill mode
- busy  output  1  high in READ, WRITE and DONE
- done  output  1  one-cycle completion pulse
- mem_enable_write  output  1  to memory write enable
- mem_enable_read  output  1  to memory read enable
- mem_addr  output  ADDR_WIDTH  to memory address
- mem_write_data  output  DATA_WIDTH  to memory write data
- mem_read_data  input  DATA_WIDTH  from memory; registered there, valid the cycle after a read edge

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: on a clock edge with start=1, latch src_ptr, dst_ptr, remaining=length, mode and fill_value. length=0 goes to DONE. Otherwise copy goes to READ and fill goes to WRITE.
- READ: mem_enable_read=1, mem_addr=src_ptr. Next state is WRITE, and src_ptr increments.
- WRITE: mem_enable_write=1, mem_addr=dst_ptr.
  - mem_write_data = mem_read_data in copy mode, fill_value in fill mode.
  - dst_ptr increments and remaining decrements.
  - If remaining was 1, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 for one cycle, then IDLE.
- All mem_* outputs are decoded combinationally from registered state and pointers. In IDLE and DONE both enables are 0, mem_addr=0 and mem_write_data=0.
- start while busy is ignored. No queuing. Input changes after acceptance have no effect.
- Pointer wrap: address 255 increments to 0 and the transfer continues.
- Overlap: copy proceeds strictly forward, one byte at a time. With dst in (src, src+length), each byte is read after earlier writes in the same transfer, so bytes propagate forward. This is defined behaviour.

## Timing
- Reset (asynchronous assert): state IDLE, busy=0, done=0, all mem_* outputs 0, pointers and remaining 0, effective immediately. A transfer interrupted by reset leaves already-written bytes in memory and issues no further accesses.
- Start accepted at edge E0. The first memory access is driven in the cycle after E0.
- Copy of N bytes takes 2N access cycles. done is high in cycle 2N+1 after E0, and busy falls at the following edge.
- Fill of N bytes takes N access cycles. done is high in cycle N+1.
- length=0 gives done in cycle 1 after E0 with no memory access.
- Read-to-write: the read edge at the end of READ loads the memory's read_data. The WRITE cycle forwards it that same cycle, with no extra wait state.
- A new start is accepted earliest at the edge where state is IDLE again, one cycle after done.

## Structure
- Shared package `mem_copy_pkg`:
  - state enum encodings (IDLE=0, READ=1, WRITE=2, DONE=3)
  - mode constants MODE_COPY=0, MODE_FILL=1
  - ADDR_WIDTH/DATA_WIDTH defaults
- Single module. No sub-module is warranted; pointer and counter logic stays inline.
- The bench instantiates the existing data memory as the responder, preloaded from a memory image.

## Test plan
- Copy src=0x10, dst=0x80, length=4, memory[0x10..0x13]=A1,B2,C3,D4 -> memory[0x80..0x83]=A1,B2,C3,D4. done in cycle 9 after start. Read and write enables are never high together.
- Fill dst=0x20, length=3, fill_value=0x5A -> memory[0x20..0x22]=5A. mem_enable_read never asserted. done in cycle 4.
- Copy src=0xFE, dst=0x00, length=4 -> source addresses FE,FF,00,01 and destination addresses 00,01,02,03, showing wrap on both pointers.
- length=0 -> no memory enables, done pulse in cycle 1, busy low again two cycles after start.
- Second start pulsed mid-transfer with different parameters -> ignored. The original transfer completes unchanged with exactly one done.
- Reset asserted between clock edges during WRITE of byte 2 of 4 -> all outputs 0 immediately. Bytes 0–1 written, bytes 2–3 untouched. A post-reset start runs normally.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the memory copy/fill engine.
package mem_copy_pkg;

  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Single-port data memory bus between the engine (master) and the memory (slave).
interface mem_copy_engine_if
  import mem_copy_pkg::*;
();

  logic                  mem_enable_write;
  logic                  mem_enable_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output mem_enable_write,
    output mem_enable_read,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_enable_write,
    input  mem_enable_read,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Copy or fill engine: one memory access per cycle, read and write never together.
module mem_copy_engine
  import mem_copy_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic [DATA_WIDTH-1:0] fill_value_i,
  output logic                  busy_o,
  output logic                  done_o,
  mem_copy_engine_if.master     mem_if
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;

  logic                  we_c;
  logic                  re_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  // State, pointers and latched transfer parameters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state and memory bus decode; the bus is idle (all zero) in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    we_c    = 1'b0;
    re_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          rem_d  = length_i;
          mode_d = mode_i;
          fill_d = fill_value_i;
          if (length_i == '0) begin
            state_d = ST_DONE;
          end else if (mode_i == MODE_FILL) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        re_c    = 1'b1;
        addr_c  = src_q;
        src_d   = src_q + ADDR_WIDTH'(1);
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        we_c    = 1'b1;
        addr_c  = dst_q;
        // The memory registers read data on the READ edge, so it is forwarded here directly.
        wdata_c = (mode_q == MODE_FILL) ? fill_q : mem_if.mem_read_data;
        dst_d   = dst_q + ADDR_WIDTH'(1);
        rem_d   = rem_q - LEN_WIDTH'(1);
        if (rem_q == LEN_WIDTH'(1)) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_FILL) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_if.mem_enable_write = we_c;
  assign mem_if.mem_enable_read  = re_c;
  assign mem_if.mem_addr         = addr_c;
  assign mem_if.mem_write_data   = wdata_c;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural registered-read data memory.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  mode = 1'b0;
  logic [ADDR_WIDTH-1:0] src_addr = '0;
  logic [ADDR_WIDTH-1:0] dst_addr = '0;
  logic [LEN_WIDTH-1:0]  length = '0;
  logic [DATA_WIDTH-1:0] fill_value = '0;
  logic                  busy;
  logic                  done;

  mem_copy_engine_if bus ();

  mem_copy_engine dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .mode_i       (mode),
    .src_addr_i   (src_addr),
    .dst_addr_i   (dst_addr),
    .length_i     (length),
    .fill_value_i (fill_value),
    .busy_o       (busy),
    .done_o       (done),
    .mem_if       (bus)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, synchronous write, plus a bench load port for the image.
  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_enable_write) mem[bus.mem_addr] <= bus.mem_write_data;
    if (bus.mem_enable_read) bus.mem_read_data <= mem[bus.mem_addr];
  end

  // Bus monitor, sampled mid-cycle; it is the only writer of the logs.
  int gcyc = 0;
  int both_cnt = 0;
  int rd_log[$];
  int wa_log[$];
  int wd_log[$];
  int done_log[$];

  always @(negedge clk) begin
    gcyc++;
    if (bus.mem_enable_read) rd_log.push_back(int'(bus.mem_addr));
    if (bus.mem_enable_write) begin
      wa_log.push_back(int'(bus.mem_addr));
      wd_log.push_back(int'(bus.mem_write_data));
    end
    if (done) done_log.push_back(gcyc);
    if (bus.mem_enable_read && bus.mem_enable_write) both_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int e0, rd_base, wr_base, done_base;

  task automatic do_start(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] n, input logic [7:0] fv);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = n; fill_value = fv; start = 1'b1;
    @(posedge clk);
    e0        = gcyc;
    rd_base   = rd_log.size();
    wr_base   = wa_log.size();
    done_base = done_log.size();
    #1 start = 1'b0;
  endtask

  // Returns just after the edge that follows the done cycle, with done cycle checked.
  task automatic wait_done(input string tag, input int exp_cyc);
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done_log.size() > done_base) begin
        seen = 1;
        break;
      end
      @(posedge clk);
    end
    #1;
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      check({tag, "_done_cyc"}, 32'(done_log[done_base] - e0), 32'(exp_cyc));
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  logic [15:0] img [33] = '{
    16'h10A1, 16'h11B2, 16'h12C3, 16'h13D4, 16'h8000, 16'h8100, 16'h8200, 16'h8300,
    16'h2000, 16'h2100, 16'h2200, 16'h2311,
    16'hFE11, 16'hFF22, 16'h0033, 16'h0144, 16'h0200, 16'h0300,
    16'h4001, 16'h4102, 16'h4203, 16'h6000, 16'h6100, 16'h6200, 16'h9000,
    16'h509A, 16'h519B, 16'h529C, 16'h539D, 16'h7000, 16'h7100, 16'h7200, 16'h7300
  };

  logic [7:0] exp_b [4];

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(bus.mem_enable_write), 32'd0);
    check("rst_re", 32'(bus.mem_enable_read), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_write_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 33; i++) load(img[i][15:8], img[i][7:0]);

    // Copy 4 bytes 0x10 -> 0x80
    do_start(MODE_COPY, 8'h10, 8'h80, 9'd4, 8'h00);
    wait_done("copy", 9);
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("copy_mem%0d", i), 32'(mem[8'h80 + i]), 32'(exp_b[i]));
      check($sformatf("copy_rd%0d", i), 32'(rd_log[rd_base + i]), 32'h10 + i);
    end
    check("copy_wr_cnt", 32'(wa_log.size() - wr_base), 32'd4);
    check("copy_done_cnt", 32'(done_log.size() - done_base), 32'd1);

    // Fill 3 bytes at 0x20 with 0x5A
    do_start(MODE_FILL, 8'h00, 8'h20, 9'd3, 8'h5A);
    wait_done("fill", 4);
    for (int i = 0; i < 3; i++) check($sformatf("fill_mem%0d", i), 32'(mem[8'h20 + i]), 32'h5A);
    check("fill_mem_after", 32'(mem[8'h23]), 32'h11);
    check("fill_rd_cnt", 32'(rd_log.size() - rd_base), 32'd0);

    // Copy across the wrap point; dst overlaps src so bytes propagate forward
    do_start(MODE_COPY, 8'hFE, 8'h00, 9'd4, 8'h00);
    wait_done("wrap", 9);
    check("wrap_rd0", 32'(rd_log[rd_base + 0]), 32'hFE);
    check("wrap_rd1", 32'(rd_log[rd_base + 1]), 32'hFF);
    check("wrap_rd2", 32'(rd_log[rd_base + 2]), 32'h00);
    check("wrap_rd3", 32'(rd_log[rd_base + 3]), 32'h01);
    exp_b = '{8'h11, 8'h22, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_wa%0d", i), 32'(wa_log[wr_base + i]), 32'(i));
      check($sformatf("wrap_wd%0d", i), 32'(wd_log[wr_base + i]), 32'(exp_b[i]));
      check($sformatf("wrap_mem%0d", i), 32'(mem[i]), 32'(exp_b[i]));
    end

    // Zero length: done in cycle 1, no accesses, busy low at cycle 2
    do_start(MODE_COPY, 8'h33, 8'h44, 9'd0, 8'h00);
    wait_done("zero", 1);
    check("zero_rd_cnt", 32'(rd_log.size() - rd_base), 32'd0);
    check("zero_wr_cnt", 32'(wa_log.size() - wr_base), 32'd0);

    // Start while busy is ignored
    do_start(MODE_COPY, 8'h40, 8'h60, 9'd3, 8'h00);
    repeat (2) @(negedge clk);
    mode = MODE_FILL; dst_addr = 8'h90; length = 9'd2; fill_value = 8'hEE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 7);
    repeat (4) @(posedge clk);
    #1;
    check("busy_start_done_cnt", 32'(done_log.size() - done_base), 32'd1);
    check("busy_start_wr_cnt", 32'(wa_log.size() - wr_base), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("busy_start_mem%0d", i), 32'(mem[8'h60 + i]), 32'(i + 1));
    check("busy_start_mem90", 32'(mem[8'h90]), 32'h00);

    // Reset asynchronously in the WRITE cycle of byte 2
    do_start(MODE_COPY, 8'h50, 8'h70, 9'd4, 8'h00);
    repeat (5) @(posedge clk);
    #3;
    check("arst_pre_we", 32'(bus.mem_enable_write), 32'd1);
    check("arst_pre_addr", 32'(bus.mem_addr), 32'h72);
    rst = 1'b1;
    #1;
    check("arst_we", 32'(bus.mem_enable_write), 32'd0);
    check("arst_re", 32'(bus.mem_enable_read), 32'd0);
    check("arst_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_wdata", 32'(bus.mem_write_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("arst_wr_cnt", 32'(wa_log.size() - wr_base), 32'd2);
    check("arst_mem0", 32'(mem[8'h70]), 32'h9A);
    check("arst_mem1", 32'(mem[8'h71]), 32'h9B);
    check("arst_mem2", 32'(mem[8'h72]), 32'h00);
    check("arst_mem3", 32'(mem[8'h73]), 32'h00);

    do_start(MODE_COPY, 8'h52, 8'h72, 9'd2, 8'h00);
    wait_done("post_rst", 5);
    check("post_rst_mem2", 32'(mem[8'h72]), 32'h9C);
    check("post_rst_mem3", 32'(mem[8'h73]), 32'h9D);

    check("rd_wr_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
